eth_tx_frame_gen: RTL

- Transmit-side counterpart of the receive header path.
- Builds one Ethernet frame per start request and streams it out as 8-bit AXI-Stream beats toward the tri-mode MAC TX client interface.
- Frame layout: 14-byte header (dst MAC, src MAC, EtherType/length), then a generated payload pattern, tlast on the final byte.
- Enforces an inter-frame idle gap and keeps a frame counter for the pattern-generator status.

---
 rtl/eth_tx_pkg.sv | 35 +++
 rtl/eth_tx_frame_gen_byte_counter.sv | 37 +++
 rtl/eth_tx_frame_gen.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX frame generator.
// Optional build macro: ETH_TX_PRBS_PAYLOAD_EN (PRBS payload instead of
// incrementing bytes); the LFSR helpers here are only used in that build.
package eth_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } tx_state_e;

    localparam int unsigned ETH_HDR_BYTES = 14;

    typedef logic [47:0] mac_addr_t;

    // x^8+x^6+x^5+x^4+1, Fibonacci form shifting left: taps on bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hFF;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    // Byte idx of the 14-byte header, each field sent MSB first.
    function automatic logic [7:0] hdr_byte(input mac_addr_t   dst,
                                            input mac_addr_t   src,
                                            input logic [15:0] etype,
                                            input logic [3:0]  idx);
        logic [8*ETH_HDR_BYTES-1:0] hdr;
        hdr = {dst, src, etype} << {idx, 3'b000};
        return hdr[8*ETH_HDR_BYTES-1 -: 8];
    endfunction

endpackage

// File: rtl/eth_tx_frame_gen_byte_counter.sv
// Header byte index counter: counts 0..13 on enable, wraps to 0 after 13.
module tx_byte_counter
    import eth_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output logic [3:0] idx_o,
    output logic       last_o
);

    localparam logic [3:0] LAST_IDX = 4'(ETH_HDR_BYTES - 1);

    logic [3:0] idx_q;
    logic [3:0] idx_d;

    // Next index: advance on enable, wrap after the last header byte.
    always_comb begin
        idx_d = idx_q;
        if (en_i) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 4'd1;
        end
    end

    // Index register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/eth_tx_frame_gen.sv
// Ethernet TX frame generator: 14-byte header, generated payload, idle gap.
// Optional build macro: ETH_TX_PRBS_PAYLOAD_EN selects an LFSR payload
// (seed 8'hFF per frame) instead of the incrementing-byte payload.
module eth_tx_frame_gen
    import eth_tx_pkg::*;
#(
    parameter int unsigned LEN_W       = 11,
    parameter int unsigned MIN_PAYLOAD = 46,
    parameter int unsigned MAX_PAYLOAD = 1500,
    parameter int unsigned GAP_CYCLES  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [47:0]      dst_mac,
    input  logic [47:0]      src_mac,
    input  logic [15:0]      eth_type,
    input  logic [LEN_W-1:0] payload_len,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_count,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

    localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_PAYLOAD);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_PAYLOAD);

    tx_state_e        state_q, state_d;
    mac_addr_t        dst_q, dst_d;
    mac_addr_t        src_q, src_d;
    logic [15:0]      type_q, type_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] pay_cnt_q, pay_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic [7:0]       tdata_q, tdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      count_q, count_d;
`ifdef ETH_TX_PRBS_PAYLOAD_EN
    logic [7:0]       lfsr_q, lfsr_d;
`endif

    logic       accept;
    logic       hdr_adv;
    logic [3:0] hdr_idx;
    logic       hdr_last;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l < MIN_LEN) return MIN_LEN;
        if (l > MAX_LEN) return MAX_LEN;
        return l;
    endfunction

    assign accept = tvalid_q & m_axis_tready;

    tx_byte_counter u_hdr_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (hdr_adv),
        .idx_o  (hdr_idx),
        .last_o (hdr_last)
    );

    // Next-state and next-beat logic; output registers always hold the
    // beat currently presented, so the next beat is prepared on each handshake.
    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        src_d     = src_q;
        type_d    = type_q;
        len_d     = len_q;
        pay_cnt_d = pay_cnt_q;
        gap_cnt_d = gap_cnt_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tdata_d   = tdata_q;
        done_d    = 1'b0;
        count_d   = count_q;
        hdr_adv   = 1'b0;
`ifdef ETH_TX_PRBS_PAYLOAD_EN
        lfsr_d    = lfsr_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = HEADER;
                    dst_d     = dst_mac;
                    src_d     = src_mac;
                    type_d    = eth_type;
                    len_d     = clamp_len(payload_len);
                    pay_cnt_d = '0;
                    tvalid_d  = 1'b1;
                    tlast_d   = 1'b0;
                    tdata_d   = dst_mac[47:40];
`ifdef ETH_TX_PRBS_PAYLOAD_EN
                    lfsr_d    = LFSR_SEED;
`endif
                end
            end
            HEADER: begin
                if (accept) begin
                    hdr_adv = 1'b1;
                    if (hdr_last) begin
                        state_d   = PAYLOAD;
                        pay_cnt_d = '0;
                        tlast_d   = (len_q == LEN_W'(1));
`ifdef ETH_TX_PRBS_PAYLOAD_EN
                        tdata_d   = lfsr_q;
`else
                        tdata_d   = 8'h00;
`endif
                    end else begin
                        tdata_d = hdr_byte(dst_q, src_q, type_q, hdr_idx + 4'd1);
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (tlast_q) begin
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                        tdata_d   = '0;
                        done_d    = 1'b1;
                        count_d   = count_q + 16'd1;
                        gap_cnt_d = '0;
                        state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        pay_cnt_d = pay_cnt_q + LEN_W'(1);
                        tlast_d   = (pay_cnt_q + LEN_W'(2) == len_q);
`ifdef ETH_TX_PRBS_PAYLOAD_EN
                        lfsr_d    = lfsr_next(lfsr_q);
                        tdata_d   = lfsr_next(lfsr_q);
`else
                        tdata_d   = pay_cnt_d[7:0];
`endif
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dst_q     <= '0;
            src_q     <= '0;
            type_q    <= '0;
            len_q     <= '0;
            pay_cnt_q <= '0;
            gap_cnt_q <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
`ifdef ETH_TX_PRBS_PAYLOAD_EN
            lfsr_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            type_q    <= type_d;
            len_q     <= len_d;
            pay_cnt_q <= pay_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdata_q   <= tdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            count_q   <= count_d;
`ifdef ETH_TX_PRBS_PAYLOAD_EN
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign frame_count   = count_q;

endmodule
